mackerel_dtack_gen: RTL and testbench
=====================================

// Module: mackerel_dtack_gen
// PURPOSE
//  Bus-cycle responder for the 68k bus: closes every CPU cycle with DTACK or BERR.
//  Takes the active-low chip selects from the address decoder plus AS and inserts per-region wait states.
//  Passes the MFP's own DTACK through and terminates unmapped or hung cycles.
//  Sits beside the decoder, clocked by CLK_GEN (CPU clock); outputs drive CPU /DTACK and /BERR.
// PARAMETERS
//  ROM_WS          2    wait states (CLK cycles) before DTACK for ROM cycles
//  RAM_WS          0    wait states before DTACK for RAM0 cycles
//  TIMEOUT_CYCLES  64   cycles from AS low to BERR when no ack arrives (>= max(ROM_WS,RAM_WS)+2)
// PORTS
//  CLK        in   1  CPU clock (CLK_GEN); all state changes on posedge
//  RST        in   1  asynchronous, active-low reset
//  AS         in   1  CPU address strobe, active-low
//  ROMEN      in   1  ROM select from decoder, active-low (already AS-qualified)
//  RAMEN0     in   1  RAM bank 0 select, active-low (already AS-qualified)
//  MFPEN      in   1  MFP select, active-low, NOT AS-qualified; qualified internally with ~AS
//  MFP_DTACK  in   1  MFP data ack, active-low
//  DTACK      out  1  to CPU, active-low, registered
//  BERR       out  1  to CPU, active-low, registered
// BEHAVIOUR
//  Reset: state IDLE, counters 0, DTACK=1, BERR=1; async assert, removed synchronously to CLK.
//  States: IDLE, WAIT, MFP, ACK, ERR, DONE.
//  IDLE: edge with AS=0 latches region; priority ROM > RAM0 > MFP > unmapped.
//   ROM/RAM: ws=0 -> ACK (DTACK=0 at this edge), else load count=ws, go WAIT.
//   MFP -> MFP. Unmapped -> WAIT with no ack source; only the timeout ends it.
//  WAIT: count decrements each edge; at count==1 the edge moves to ACK, DTACK=0.
//   Result: DTACK falls on edge N+ws, where N is the AS-detect edge.
//  MFP: first edge sampling MFP_DTACK=0 -> ACK (one-cycle registered pass-through).
//  ACK: hold DTACK=0 until an edge samples AS=1, then DTACK=1 and go IDLE.
//  ERR: hold BERR=0 until an edge samples AS=1, then BERR=1 and go IDLE.
//  Aborted cycle: AS=1 sampled in WAIT/MFP -> IDLE, no DTACK or BERR.
//  Back-to-back: AS must be seen high for >=1 edge before a new cycle is accepted.
//   A cycle whose AS never rises stays in ACK/ERR.
//  Timeout: the watchdog counts edges while state is WAIT or MFP.
//   When the count reaches TIMEOUT_CYCLES -> ERR (BERR=0).
//   If ack and timeout fall on the same edge, the ack wins.
//   Counter saturates, clears in IDLE, width $clog2(TIMEOUT_CYCLES+1).
//  DTACK and BERR are never low together; both are 1 in IDLE.
//  Reset mid-cycle: immediate return to the reset values above.
// CONFIGURATION
//  MACKEREL_BERR_TIMEOUT_EN defined: watchdog and ERR state are built as above.
//  Not defined: no watchdog; BERR tied 1.
//   Unmapped cycles are instead acked after RAM_WS wait states (DTACK), so the CPU never hangs.
//   MFP cycles wait for MFP_DTACK indefinitely.
// STRUCTURE
//  mackerel_pkg holds:
//   state enum (IDLE, WAIT, MFP, ACK, ERR, DONE)
//   region codes (REG_ROM, REG_RAM0, REG_MFP, REG_NONE)
//   localparam WS_W = 4 for the wait counter
//  Sub-module mackerel_bus_watchdog: clear/enable/terminal-count counter, instantiated only under
//   MACKEREL_BERR_TIMEOUT_EN.
//  Top: region latch, wait counter, FSM, output registers.
// TESTING
//  1. ROMEN=0, AS=0 at edge 0, ROM_WS=2 -> DTACK=0 after edge 2; AS=1 at edge 5 -> DTACK=1 after edge 5.
//  2. RAMEN0=0, AS=0, RAM_WS=0 -> DTACK=0 after the detect edge.
//     Back-to-back with one AS-high edge between -> two clean acks.
//  3. MFPEN=0, AS=0, MFP_DTACK=0 at edge 7 -> DTACK=0 after edge 8.
//     MFPEN=0 with AS=1 -> no response.
//  4. Unmapped, TIMEOUT_CYCLES=64 -> BERR=0 after edge 64 with DTACK=1 throughout.
//     Without the macro: DTACK=0 after RAM_WS edges, BERR stays 1.
//  5. ROMEN=0, AS deasserted at edge 1 (abort) -> no DTACK; next cycle normal.
//     RST=0 mid-WAIT -> DTACK=BERR=1 immediately.
//  6. ROMEN and RAMEN0 both low -> ROM_WS timing applies.
//     MFP_DTACK=0 on the timeout edge -> DTACK, no BERR.

Source files
------------

// File: rtl/mackerel_pkg.sv
// mackerel_pkg
//   Shared types for the 68k bus-cycle responder (mackerel_dtack_gen).
//   - state_e    : responder FSM states
//   - region_e   : decoded target region of the current bus cycle
//   - WS_W       : width of the wait-state counter
//   - decode_region() : priority decode of the active-low chip selects
package mackerel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_MFP,
    ST_ACK,
    ST_ERR,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    REG_ROM,
    REG_RAM0,
    REG_MFP,
    REG_NONE
  } region_e;

  localparam int unsigned WS_W = 4;

  // Priority ROM > RAM0 > MFP > unmapped. mfpen_q_n must already be
  // qualified with the address strobe by the caller.
  function automatic region_e decode_region(input logic romen_n,
                                            input logic ramen0_n,
                                            input logic mfpen_q_n);
    region_e r;
    if (!romen_n)        r = REG_ROM;
    else if (!ramen0_n)  r = REG_RAM0;
    else if (!mfpen_q_n) r = REG_MFP;
    else                 r = REG_NONE;
    return r;
  endfunction

endpackage

// File: rtl/mackerel_bus_watchdog.sv
// mackerel_bus_watchdog
//   Saturating cycle counter used to terminate hung bus cycles.
//   Counts one per clock while en_i is high, clears while clr_i is high.
//   tc_o is combinational: it is high on the edge at which the count
//   reaches TIMEOUT_CYCLES, so the owner can switch state on that same edge.
// Ports
//   clk_i   : clock, all state changes on posedge
//   rst_ni  : asynchronous active-low reset
//   clr_i   : synchronous clear (has priority over en_i)
//   en_i    : count enable
//   tc_o    : terminal count reached on this edge
module mackerel_bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count becomes TIMEOUT_CYCLES at this edge when it currently holds
  // TIMEOUT_CYCLES-1; >= also covers the saturated case.
  assign tc_o = en_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/mackerel_dtack_gen.sv
// mackerel_dtack_gen
//   68k bus-cycle responder: closes every CPU cycle with /DTACK or /BERR.
//   Inserts per-region wait states for ROM and RAM0, passes the MFP's own
//   data ack through (one registered cycle), and terminates unmapped or
//   hung cycles.
// Build option
//   MACKEREL_BERR_TIMEOUT_EN defined : watchdog + ERR state, BERR driven.
//   not defined                      : no watchdog, BERR tied high, unmapped
//                                      cycles acked after RAM_WS wait states,
//                                      MFP cycles wait for MFP_DTACK forever.
// Ports (all active-low except CLK)
//   CLK        : CPU clock, all state changes on posedge
//   RST        : asynchronous reset
//   AS         : CPU address strobe
//   ROMEN      : ROM select (AS-qualified)
//   RAMEN0     : RAM bank 0 select (AS-qualified)
//   MFPEN      : MFP select (not AS-qualified)
//   MFP_DTACK  : MFP data acknowledge
//   DTACK      : to CPU, registered
//   BERR       : to CPU, registered
module mackerel_dtack_gen
  import mackerel_pkg::*;
#(
  parameter int unsigned ROM_WS         = 2,
  parameter int unsigned RAM_WS         = 0,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic AS,
  input  logic ROMEN,
  input  logic RAMEN0,
  input  logic MFPEN,
  input  logic MFP_DTACK,
  output logic DTACK,
  output logic BERR
);

  localparam logic [WS_W-1:0] ROM_WS_C = WS_W'(ROM_WS);
  localparam logic [WS_W-1:0] RAM_WS_C = WS_W'(RAM_WS);
  localparam int unsigned MAX_WS = (ROM_WS > RAM_WS) ? ROM_WS : RAM_WS;

  if ((MAX_WS >= (1 << WS_W)) || (TIMEOUT_CYCLES < MAX_WS + 2)) begin : g_bad_params
    $error("mackerel_dtack_gen: wait states too large for counter or TIMEOUT_CYCLES too small");
  end

  state_e          state_q, state_d;
  region_e         region_q, region_d;
  logic [WS_W-1:0] wcnt_q, wcnt_d;
  logic            dtack_q, dtack_d;
  logic            tmo;
  region_e         sel;
  logic [WS_W-1:0] ws_sel;

`ifdef MACKEREL_BERR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  logic berr_q, berr_d;
  logic wd_en, wd_clr;

  assign wd_en  = (state_q == ST_WAIT) || (state_q == ST_MFP);
  assign wd_clr = (state_q == ST_IDLE);

  mackerel_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i (CLK),
    .rst_ni(RST),
    .clr_i (wd_clr),
    .en_i  (wd_en),
    .tc_o  (tmo)
  );
`else
  localparam bit TO_EN = 1'b0;
  assign tmo = 1'b0;
`endif

  // MFPEN is not strobe-qualified by the decoder, so qualify it here.
  assign sel    = decode_region(ROMEN, RAMEN0, MFPEN | AS);
  // Unmapped cycles share the RAM0 wait count when no watchdog is built.
  assign ws_sel = (sel == REG_ROM) ? ROM_WS_C : RAM_WS_C;

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    wcnt_d   = wcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!AS) begin
          region_d = sel;
          if (sel == REG_MFP) begin
            state_d = ST_MFP;
          end else if ((sel == REG_NONE) && TO_EN) begin
            // No ack source: only the watchdog can end this cycle.
            wcnt_d  = '0;
            state_d = ST_WAIT;
          end else if (ws_sel == '0) begin
            state_d = ST_ACK;
          end else begin
            wcnt_d  = ws_sel;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (AS) begin
          state_d = ST_IDLE;
        end else if ((wcnt_q == WS_W'(1)) && ((region_q != REG_NONE) || !TO_EN)) begin
          state_d = ST_ACK;
        end else if (tmo) begin
          state_d = ST_ERR;
        end else if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WS_W'(1);
        end
      end
      ST_MFP: begin
        // Ack is checked before the watchdog so it wins a same-edge tie.
        if (AS) begin
          state_d = ST_IDLE;
        end else if (!MFP_DTACK) begin
          state_d = ST_ACK;
        end else if (tmo) begin
          state_d = ST_ERR;
        end
      end
      ST_ACK, ST_ERR: begin
        if (AS) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state they belong to.
  assign dtack_d = (state_d != ST_ACK);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      region_q <= REG_NONE;
      wcnt_q   <= '0;
      dtack_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      wcnt_q   <= wcnt_d;
      dtack_q  <= dtack_d;
    end
  end

  assign DTACK = dtack_q;

`ifdef MACKEREL_BERR_TIMEOUT_EN
  assign berr_d = (state_d != ST_ERR);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      berr_q <= 1'b1;
    end else begin
      berr_q <= berr_d;
    end
  end

  assign BERR = berr_q;
`else
  assign BERR = 1'b1;
`endif

endmodule

// File: tb/tb_mackerel_dtack_gen.sv
// tb_mackerel_dtack_gen
//   Directed, table-driven bench for mackerel_dtack_gen with default
//   parameters (ROM_WS=2, RAM_WS=0, TIMEOUT_CYCLES=64). Each table row is
//   one clock edge: inputs applied before the edge, outputs expected after.
//   Multi-cycle corner cases (timeout, reset mid-cycle) are hand sequences.
module tb_mackerel_dtack_gen;

  logic CLK, RST, AS, ROMEN, RAMEN0, MFPEN, MFP_DTACK;
  logic DTACK, BERR;

  int total = 0;
  int bad   = 0;

  mackerel_dtack_gen #(
    .ROM_WS(2),
    .RAM_WS(0),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .AS       (AS),
    .ROMEN    (ROMEN),
    .RAMEN0   (RAMEN0),
    .MFPEN    (MFPEN),
    .MFP_DTACK(MFP_DTACK),
    .DTACK    (DTACK),
    .BERR     (BERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic as_n;
    logic rom_n;
    logic ram_n;
    logic mfp_n;
    logic ack_n;
    logic exp_dtack;
    logic exp_berr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic a, input logic r, input logic m, input logic f,
                     input logic k, input logic ed, input logic eb);
    vec_t v;
    v.as_n = a; v.rom_n = r; v.ram_n = m; v.mfp_n = f; v.ack_n = k;
    v.exp_dtack = ed; v.exp_berr = eb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic r, input logic m, input logic f,
                       input logic k);
    AS = a; ROMEN = r; RAMEN0 = m; MFPEN = f; MFP_DTACK = k;
  endtask

  // One edge with the given inputs; check both outputs on the falling edge.
  task automatic cyc(input string nm, input logic a, input logic r, input logic m,
                     input logic f, input logic k, input logic ed, input logic eb);
    drive(a, r, m, f, k);
    @(posedge CLK);
    @(negedge CLK);
    chk({nm, " dtack"}, DTACK, ed);
    chk({nm, " berr"}, BERR, eb);
  endtask

  initial begin
    RST = 1'b0;
    drive(1, 1, 1, 1, 1);

    // ROM cycle: DTACK falls on the 2nd edge after detect, holds until AS high
    add(0,0,1,1,1, 1,1); add(0,0,1,1,1, 1,1); add(0,0,1,1,1, 0,1);
    add(0,0,1,1,1, 0,1); add(0,0,1,1,1, 0,1); add(1,1,1,1,1, 1,1);
    // RAM0 zero wait, back-to-back with one AS-high edge between
    add(0,1,0,1,1, 0,1); add(0,1,0,1,1, 0,1); add(1,1,1,1,1, 1,1);
    add(0,1,0,1,1, 0,1); add(1,1,1,1,1, 1,1);
    // ROM and RAM0 both selected: ROM timing
    add(0,0,0,1,1, 1,1); add(0,0,0,1,1, 1,1); add(0,0,0,1,1, 0,1);
    add(1,1,1,1,1, 1,1);
    // MFP with ack already low at detect edge: DTACK one edge later
    add(0,1,1,0,0, 1,1); add(0,1,1,0,0, 0,1); add(1,1,1,1,1, 1,1);
    // MFPEN low without AS: no response, still idle (RAM acks at once)
    add(1,1,1,0,1, 1,1); add(1,1,1,0,0, 1,1); add(0,1,0,1,1, 0,1);
    add(1,1,1,1,1, 1,1);
    // MFP with late ack; DTACK holds after MFP_DTACK releases
    add(0,1,1,0,1, 1,1); add(0,1,1,0,1, 1,1); add(0,1,1,0,1, 1,1);
    add(0,1,1,0,0, 0,1); add(0,1,1,0,1, 0,1); add(1,1,1,0,1, 1,1);
    // ROM abort at edge 1, then a normal ROM cycle
    add(0,0,1,1,1, 1,1); add(1,1,1,1,1, 1,1); add(1,1,1,1,1, 1,1);
    add(0,0,1,1,1, 1,1); add(0,0,1,1,1, 1,1); add(0,0,1,1,1, 0,1);
    add(1,1,1,1,1, 1,1);
    // MFP abort: AS high beats a same-edge MFP ack
    add(0,1,1,0,1, 1,1); add(1,1,1,0,0, 1,1); add(1,1,1,1,1, 1,1);
    add(0,1,0,1,1, 0,1); add(1,1,1,1,1, 1,1);

    #12;
    chk("reset dtack", DTACK, 1'b1);
    chk("reset berr", BERR, 1'b1);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc($sformatf("vec%0d", i), vecs[i].as_n, vecs[i].rom_n, vecs[i].ram_n,
          vecs[i].mfp_n, vecs[i].ack_n, vecs[i].exp_dtack, vecs[i].exp_berr);
    end

    // Unmapped cycle
`ifdef MACKEREL_BERR_TIMEOUT_EN
    cyc("unmap detect", 0,1,1,1,1, 1,1);
    for (int i = 1; i < 64; i++) cyc($sformatf("unmap e%0d", i), 0,1,1,1,1, 1,1);
    cyc("unmap e64", 0,1,1,1,1, 1,0);
    cyc("unmap hold", 0,1,1,1,1, 1,0);
    cyc("unmap release", 1,1,1,1,1, 1,1);
`else
    cyc("unmap detect", 0,1,1,1,1, 0,1);
    cyc("unmap hold", 0,1,1,1,1, 0,1);
    cyc("unmap release", 1,1,1,1,1, 1,1);
`endif

    // MFP ack vs. timeout
`ifdef MACKEREL_BERR_TIMEOUT_EN
    cyc("mfptie detect", 0,1,1,0,1, 1,1);
    for (int i = 1; i < 64; i++) cyc($sformatf("mfptie e%0d", i), 0,1,1,0,1, 1,1);
    cyc("mfptie e64", 0,1,1,0,0, 0,1);
    cyc("mfptie release", 1,1,1,1,1, 1,1);
    cyc("mfphang detect", 0,1,1,0,1, 1,1);
    for (int i = 1; i < 64; i++) cyc($sformatf("mfphang e%0d", i), 0,1,1,0,1, 1,1);
    cyc("mfphang e64", 0,1,1,0,1, 1,0);
    cyc("mfphang release", 1,1,1,1,1, 1,1);
`else
    cyc("mfpwait detect", 0,1,1,0,1, 1,1);
    for (int i = 1; i < 100; i++) cyc($sformatf("mfpwait e%0d", i), 0,1,1,0,1, 1,1);
    cyc("mfpwait ack", 0,1,1,0,0, 0,1);
    cyc("mfpwait release", 1,1,1,1,1, 1,1);
`endif

    // Reset mid-WAIT
    cyc("rstwait detect", 0,0,1,1,1, 1,1);
    #2 RST = 1'b0;
    #1;
    chk("rstwait dtack", DTACK, 1'b1);
    chk("rstwait berr", BERR, 1'b1);
    @(negedge CLK);
    drive(1,1,1,1,1);
    RST = 1'b1;

    // Reset while DTACK is asserted: must release without a clock edge
    cyc("rstack c0", 0,0,1,1,1, 1,1);
    cyc("rstack c1", 0,0,1,1,1, 1,1);
    cyc("rstack c2", 0,0,1,1,1, 0,1);
    #2 RST = 1'b0;
    #1;
    chk("rstack async dtack", DTACK, 1'b1);
    chk("rstack async berr", BERR, 1'b1);
    @(posedge CLK);
    @(negedge CLK);
    chk("rstack held dtack", DTACK, 1'b1);
    drive(1,1,1,1,1);
    RST = 1'b1;

    // Full ROM timing again after reset
    cyc("post c0", 0,0,1,1,1, 1,1);
    cyc("post c1", 0,0,1,1,1, 1,1);
    cyc("post c2", 0,0,1,1,1, 0,1);
    cyc("post rel", 1,1,1,1,1, 1,1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
